// File: rtl/ifetch_unit_pkg.sv
// Shared constants, types and helpers for the instruction fetch unit.
//   XLEN / ILEN      : address width and instruction word width
//   STARTUP_OFFSET   : fetch address after reset
//   NOP_INST         : instruction presented to decode when no fetch is valid
//   IFETCH_DEPTH     : default instruction buffer depth
//   fetch_entry_t    : one buffered instruction {inst, pc_next}
package ifetch_unit_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned IFETCH_DEPTH = 2;

  localparam logic [XLEN-1:0] STARTUP_OFFSET = 64'h0000_0000_8000_0000;
  localparam logic [ILEN-1:0] NOP_INST       = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc_next;
  } fetch_entry_t;

  // Sequential next PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Synchronous instruction buffer holding {inst, pc_next} entries.
//   clk, rst            : clock, asynchronous active-low reset
//   push, push_inst,
//   push_pc_next        : write one entry (caller guarantees not full)
//   pop                 : drop head entry (caller guarantees not empty)
//   flush               : empty the buffer; wins over push/pop
//   head_inst,
//   head_pc_next        : head entry (undefined when empty)
//   count, empty, full  : occupancy
module ifetch_unit_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ILEN-1:0]         push_inst,
  input  logic [XLEN-1:0]         push_pc_next,
  input  logic                    pop,
  input  logic                    flush,
  output logic [ILEN-1:0]         head_inst,
  output logic [XLEN-1:0]         head_pc_next,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= '{inst: push_inst, pc_next: push_pc_next};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_inst    = mem_q[rd_ptr_q].inst;
  assign head_pc_next = mem_q[rd_ptr_q].pc_next;
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == (PtrW+1)'(DEPTH));

endmodule

// File: rtl/ifetch_unit.sv
// Fetch-stage producer: generates the fetch PC, issues requests to instruction
// memory under a credit limit, buffers in-order responses and presents the
// head instruction to the fetch->decode register. Redirects flush the buffer
// and discard responses still in flight.
//   clk, rst                    : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr   : fetch request port (request may be withdrawn)
//   imem_rsp_valid/data         : in-order response, no backpressure
//   stall                       : decode holds the current output
//   redirect_valid/pc           : control-flow change from execute
//   fetch_inst/pc_next/invalid  : output to the pipeline register
//   fetch_misaligned            : only with IFETCH_MISALIGN_TRAP_EN defined;
//                                 sticky flag for a misaligned redirect target
// Build option: IFETCH_MISALIGN_TRAP_EN enables the misaligned-target trap;
// otherwise redirect_pc[1:0] is ignored.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = IFETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [ILEN-1:0] fetch_inst,
  output logic [XLEN-1:0] fetch_pc_next,
  output logic            fetch_invalid
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] DepthCnt = (CntW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy;
  logic            empty, full;
  logic            accept, push, pop, issue_ok;
  logic [XLEN-1:0] target_pc;
  logic            target_bad;
  logic [ILEN-1:0] head_inst;
  logic [XLEN-1:0] head_pc_next;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign target_bad       = (redirect_pc[1:0] != 2'b00);
  assign target_pc        = redirect_pc;
  assign issue_ok         = !misaligned_q;
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      misaligned_q <= target_bad;
    end
  end
`else
  assign target_bad = 1'b0;
  assign target_pc  = align_pc(redirect_pc);
  assign issue_ok   = 1'b1;
`endif

  // Credit covers both in-flight requests and buffered entries, so a kept
  // response always finds a free slot.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, count};
  assign imem_req_valid = rst && issue_ok && !redirect_valid && (occupancy < DepthCnt);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop  = !empty && !stall && !redirect_valid;

  always_comb begin
    inflight_d = inflight_q + CntW'(accept) - CntW'(imem_rsp_valid);

    // On redirect every request still outstanding after this cycle is stale.
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = inflight_d;
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CntW'(1);
    end

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = target_pc;
    end else if (accept) begin
      pc_d = pc_inc(pc_q);
    end

    // Address of the next kept response; tags buffered entries.
    resp_pc_d = resp_pc_q;
    if (redirect_valid) begin
      resp_pc_d = target_pc;
    end else if (push) begin
      resp_pc_d = pc_inc(resp_pc_q);
    end

    last_pc_d = last_pc_q;
    if (redirect_valid && target_bad) begin
      last_pc_d = redirect_pc;
    end else if (pop) begin
      last_pc_d = head_pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= STARTUP_OFFSET;
      resp_pc_q  <= STARTUP_OFFSET;
      last_pc_q  <= STARTUP_OFFSET;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  ifetch_unit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_inst    (imem_rsp_data),
    .push_pc_next (pc_inc(resp_pc_q)),
    .pop          (pop),
    .flush        (redirect_valid),
    .head_inst    (head_inst),
    .head_pc_next (head_pc_next),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  assign fetch_invalid = empty || redirect_valid;
  assign fetch_inst    = fetch_invalid ? NOP_INST : head_inst;
  assign fetch_pc_next = fetch_invalid ? last_pc_q : head_pc_next;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [63:0] START = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall, redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] fetch_inst;
  logic [63:0] fetch_pc_next;
  logic        fetch_invalid;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_inst     (fetch_inst),
    .fetch_pc_next  (fetch_pc_next),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .fetch_invalid  (fetch_invalid)
  );

  // Reference model: each accepted request carries the redirect epoch it was
  // issued in; a response is kept only if its epoch is still current and no
  // redirect happens in the same cycle. Kept responses form the expected
  // instruction stream.
  typedef struct {
    logic [63:0] addr;
    int unsigned epoch;
    int unsigned cyc;
  } req_t;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc_next;
  } exp_t;

  req_t        pending[$];
  exp_t        exp_q[$];
  logic [63:0] model_pc, last_pc;
  int unsigned epoch, cycle;
  logic        exp_rv;
  bit          running;
  int          n_cmp, n_err;
  int unsigned stall_pct, ready_pct, rsp_pct, redir_pct;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'h5A3C_0F13;
  endfunction

  function automatic logic [63:0] pick_target();
    case ($urandom_range(3))
      0:       return 64'h0000_0000_8000_1000;
      1:       return 64'hFFFF_FFFF_FFFF_FFF8;
      2:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Stimulus and memory model: inputs at negedge, model update at negedge+2.
  initial begin : driver
    req_t r;
    stall = 0; redirect_valid = 0; redirect_pc = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (!running) continue;
      stall          = ($urandom_range(99) < stall_pct);
      imem_req_ready = ($urandom_range(99) < ready_pct);
      redirect_valid = ($urandom_range(99) < redir_pct);
      redirect_pc    = pick_target();
      if (pending.size() > 0 && pending[0].cyc < cycle && $urandom_range(99) < rsp_pct) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pending[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      #2;
      if (imem_rsp_valid) begin
        r = pending.pop_front();
        if (!redirect_valid && r.epoch == epoch)
          exp_q.push_back('{inst: mem_word(r.addr), pc_next: r.addr + 64'd4});
      end
      if (exp_rv && imem_req_ready) begin
        pending.push_back('{addr: model_pc, epoch: epoch, cyc: cycle});
        model_pc = model_pc + 64'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        model_pc = {redirect_pc[63:2], 2'b00};
      end
      cycle++;
    end
  end

  // Monitor: checks request port and output at negedge+1, consumes the
  // expected stream whenever decode takes an instruction.
  initial begin : monitor
    exp_rv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!running) continue;
      exp_rv = ((pending.size() + exp_q.size()) < DEPTH) && !redirect_valid;
      check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (exp_rv) check("req_addr", imem_req_addr, model_pc);
      if (redirect_valid || exp_q.size() == 0) begin
        check("invalid_set", 64'(fetch_invalid), 64'd1);
        check("nop_inst", 64'(fetch_inst), 64'(NOP));
        check("held_pc_next", fetch_pc_next, last_pc);
      end else begin
        check("invalid_clr", 64'(fetch_invalid), 64'd0);
        check("inst", 64'(fetch_inst), 64'(exp_q[0].inst));
        check("pc_next", fetch_pc_next, exp_q[0].pc_next);
        if (!stall) begin
          last_pc = exp_q[0].pc_next;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic phase(input int unsigned s, input int unsigned rd, input int unsigned rs,
                       input int unsigned rdr, input int unsigned cycles);
    @(posedge clk);
    stall_pct = s; ready_pct = rd; rsp_pct = rs; redir_pct = rdr;
    repeat (cycles) @(posedge clk);
  endtask

  initial begin : main
    int unsigned waited;
    n_cmp = 0; n_err = 0; running = 0;
    stall_pct = 0; ready_pct = 0; rsp_pct = 0; redir_pct = 0;
    model_pc = START; last_pc = START; epoch = 0; cycle = 1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_invalid", 64'(fetch_invalid), 64'd1);
    check("rst_inst", 64'(fetch_inst), 64'(NOP));
    check("rst_pc_next", fetch_pc_next, START);
    rst = 1'b1;
    @(posedge clk);
    running = 1;

    phase(0, 100, 100, 0, 20);     // streaming, 1-cycle memory
    phase(100, 100, 100, 0, 8);    // decode stalled, credit must cap fetch
    phase(0, 100, 100, 0, 6);
    phase(30, 70, 60, 8, 1500);    // mixed random traffic with redirects
    phase(20, 80, 50, 40, 300);    // dense back-to-back redirects
    phase(0, 100, 100, 0, 20);

    // Drain: no new requests, deliver and consume everything outstanding.
    @(posedge clk);
    stall_pct = 0; ready_pct = 0; rsp_pct = 100; redir_pct = 0;
    waited = 0;
    while ((pending.size() > 0 || exp_q.size() > 0) && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    check("drain_done", 64'(pending.size() + exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    running = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
